mul_chain_sched: RTL and testbench
==================================

Name: mul_chain_sched

Overview:
- Round-robin scheduler that shares one mul_chain_bf16 instance among N_REQ requesters.
- Each request carries one 32-bit operand word and a 2-bit chain mode.
- Issues one mul_stb per accepted request, tags it in an in-order tag FIFO, and routes each chain result back to the issuing requester.
- Changing the chain mode requires the chain to be empty first: the block waits for all in-flight operations to complete, then inserts a one-cycle switch step.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DEPTH, 8, maximum in-flight operations and tag FIFO depth (power of 2).
- MODE_RST, 2'b11, chain_mode value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  N_REQ  per-requester request.
- req_ready  out  N_REQ  one-hot grant; a request is accepted when req_valid & req_ready.
- req_data  in  N_REQ*32  operand word; requester i uses bits [32*i+31:32*i].
- req_mode  in  N_REQ*2  requested chain mode.
- rsp_valid  out  N_REQ  one-cycle result pulse to requester i.
- rsp_data  out  32  result word, valid with any rsp_valid bit.
- chain_ins  out  32  to mul_ins.
- chain_stb  out  1  to mul_stb.
- chain_mode  out  2  to mode.
- chain_res  in  32  final-stage result of the chain.
- chain_res_stb  in  1  result valid.
- inflight  out  $clog2(DEPTH)+1  current outstanding operation count.
- err_underflow  out  1  sticky flag: a result arrived with no tag pending.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, chain_ins=0, chain_stb=0, chain_mode=MODE_RST, inflight=0, err_underflow=0. Round-robin pointer=0, FSM=RUN, tag FIFO empty.
- Reset mid-operation clears all state, drops every pending tag and ignores results until after reset is released. The chain is assumed to be reset by the same signal.
- Arbitration:
  - The winner is the first requester with valid asserted, searching from ptr upward (cyclic).
  - When a winner is accepted, ptr becomes winner+1 mod N_REQ.
  - During DRAIN/SWITCH the winner is locked and ptr does not move, so the locked requester cannot be starved.
- FSM states:
  - RUN:
    - Winner mode == chain_mode and inflight < DEPTH: req_ready[winner]=1 (combinational).
    - Winner mode != chain_mode and inflight > 0: go to DRAIN.
    - Winner mode != chain_mode and inflight == 0: go to SWITCH.
  - DRAIN: no grants; when inflight == 0, go to SWITCH.
  - SWITCH: chain_mode <= locked winner's mode; no grant this cycle; return to RUN next cycle.
- Issue (request accepted at cycle t):
  - At t+1: chain_stb=1 and chain_ins=req_data[winner] (registered outputs).
  - The tag (winner index) is pushed into the FIFO at t.
  - chain_stb is 0 in every other cycle. Maximum rate is one operation per cycle.
- Full condition: when inflight == DEPTH, no grant is given, even if a result pops in the same cycle.
- Result (chain_res_stb at cycle r):
  - The FIFO head tag is popped.
  - At r+1: rsp_valid[tag]=1 and rsp_data=chain_res.
  - No backpressure: requesters must accept the pulse.
- inflight counting:
  - +1 on accept, −1 on result. Both in the same cycle leave it unchanged.
  - chain_res_stb with an empty FIFO sets err_underflow and does not change inflight or rsp_valid.
- Results are assumed to return in issue order; the chain is fixed-latency.

Optional Feature:
- Macro MUL_SCHED_PERF_EN.
  - Defined: adds output ports issue_cnt[31:0], stall_cnt[31:0] and switch_cnt[15:0], all reset to 0 and wrapping on overflow.
    - issue_cnt counts accepted requests.
    - stall_cnt counts cycles where any req_valid is 1 but no grant is given.
    - switch_cnt counts SWITCH entries.
  - Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single op: rst low→high, req_valid[0]=1, mode 2'b11, data 0x3F80_4000, chain latency 6 → chain_stb=1 one cycle after the grant; rsp_valid[0]=1 with data echoed one cycle after the result; inflight returns to 0.
- Round-robin: all 4 requesters valid continuously with mode 11 → grant order 0,1,2,3,0,… and each rsp_valid returns to the matching index.
- Mode switch: 3 ops from req0 (mode 11) in flight, req1 asks mode 01 → no grant until inflight=0, then one SWITCH cycle, chain_mode=01, and req1 is granted the next cycle.
- Full: DEPTH=8, chain results held off → exactly 8 grants, then req_ready=0. One result arrives → one new grant one cycle later.
- Simultaneous accept and result with inflight=5 → inflight stays 5. A spurious chain_res_stb on an empty FIFO → err_underflow=1 and stays 1 until reset.
- Reset asserted with 4 ops in flight → all outputs at reset values and chain_mode=MODE_RST; results arriving after reset release produce no rsp_valid.

Source files
------------

// File: rtl/mul_chain_sched.sv
// Round-robin scheduler sharing one mul_chain_bf16 among N_REQ requesters, with in-order result routing.
// Define MUL_SCHED_PERF_EN to add the issue/stall/switch performance counter ports.
module mul_chain_sched #(
    parameter int         N_REQ    = 4,
    parameter int         DEPTH    = 8,
    parameter logic [1:0] MODE_RST = 2'b11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*32-1:0]      req_data,
    input  logic [N_REQ*2-1:0]       req_mode,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [31:0]              rsp_data,
    output logic [31:0]              chain_ins,
    output logic                     chain_stb,
    output logic [1:0]               chain_mode,
    input  logic [31:0]              chain_res,
    input  logic                     chain_res_stb,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_underflow
`ifdef MUL_SCHED_PERF_EN
    ,
    output logic [31:0]              issue_cnt,
    output logic [31:0]              stall_cnt,
    output logic [15:0]              switch_cnt
`endif
);

    localparam int PW = $clog2(N_REQ);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_REQ = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SWITCH
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   rr_idx;
    logic            rr_found;
    logic [PW-1:0]   cand_idx;
    logic            locked;
    logic [PW-1:0]   locked_idx;
    logic [1:0]      locked_mode;
    logic            use_lock;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic [1:0]      win_mode;
    logic            grant;
    logic            accept;
    logic            lock_en;
    logic            push;
    logic            pop;
    logic [PW-1:0]   tag_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [PW-1:0]   head_tag;

    // Cyclic search for the first valid requester starting at ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_idx = PW'((int'(ptr) + i) % N_REQ);
            if (!rr_found && req_valid[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // The locked requester keeps priority through drain/switch and the first RUN cycle after it.
    always_comb begin
        use_lock  = (state != ST_RUN) || (locked && req_valid[locked_idx]);
        win_idx   = use_lock ? locked_idx : rr_idx;
        win_found = use_lock ? 1'b1 : rr_found;
        win_mode  = req_mode[{win_idx, 1'b0} +: 2];
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        lock_en    = 1'b0;
        case (state)
            ST_RUN: begin
                if (win_found) begin
                    if (win_mode == chain_mode) begin
                        grant = (inflight < DEPTH_C);
                    end else begin
                        lock_en    = 1'b1;
                        next_state = (inflight != '0) ? ST_DRAIN : ST_SWITCH;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    next_state = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                next_state = ST_RUN;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    // Grants are suppressed while reset is held so req_ready shows its reset value.
    assign accept    = grant && rst;
    assign req_ready = accept ? (N_REQ'(1) << win_idx) : '0;
    assign push      = accept;
    assign pop       = chain_res_stb && (inflight != '0);
    assign head_tag  = tag_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            ptr         <= '0;
            locked      <= 1'b0;
            locked_idx  <= '0;
            locked_mode <= MODE_RST;
            chain_mode  <= MODE_RST;
        end else begin
            state  <= next_state;
            locked <= lock_en || (locked && (state != ST_RUN));
            if (lock_en) begin
                locked_idx  <= win_idx;
                locked_mode <= win_mode;
            end
            if (state == ST_SWITCH) begin
                chain_mode <= locked_mode;
            end
            if (accept) begin
                ptr <= (win_idx == LAST_REQ) ? '0 : win_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_stb <= 1'b0;
            chain_ins <= '0;
        end else begin
            chain_stb <= accept;
            if (accept) begin
                chain_ins <= req_data[{win_idx, 5'b0} +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= win_idx;
        end
    end

    // Tag FIFO pointers and occupancy; the occupancy is the inflight count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid     <= '0;
            rsp_data      <= '0;
            err_underflow <= 1'b0;
        end else begin
            rsp_valid <= pop ? (N_REQ'(1) << head_tag) : '0;
            if (pop) begin
                rsp_data <= chain_res;
            end
            if (chain_res_stb && (inflight == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef MUL_SCHED_PERF_EN
    // Free-running wrap-around counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt  <= '0;
            stall_cnt  <= '0;
            switch_cnt <= '0;
        end else begin
            if (accept) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if ((|req_valid) && !accept) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (state == ST_SWITCH) begin
                switch_cnt <= switch_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_chain_sched.sv
// Directed self-checking bench for mul_chain_sched; the chain is played by hand-timed result pulses.
module tb_mul_chain_sched;

    localparam int N_REQ = 4;
    localparam int DEPTH = 8;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*32-1:0] req_data;
    logic [N_REQ*2-1:0] req_mode;
    logic [N_REQ-1:0]   rsp_valid;
    logic [31:0]        rsp_data;
    logic [31:0]        chain_ins;
    logic               chain_stb;
    logic [1:0]         chain_mode;
    logic [31:0]        chain_res;
    logic               chain_res_stb;
    logic [3:0]         inflight;
    logic               err_underflow;

    int errors = 0;
    int checks = 0;

    mul_chain_sched #(
        .N_REQ    (N_REQ),
        .DEPTH    (DEPTH),
        .MODE_RST (2'b11)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_mode      (req_mode),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .chain_ins     (chain_ins),
        .chain_stb     (chain_stb),
        .chain_mode    (chain_mode),
        .chain_res     (chain_res),
        .chain_res_stb (chain_res_stb),
        .inflight      (inflight),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] mode);
        req_valid = valid;
        req_mode  = mode;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        checkOutput({tag, "_rsp_data"}, rsp_data, 32'h0);
        checkOutput({tag, "_chain_ins"}, chain_ins, 32'h0);
        checkOutput({tag, "_chain_stb"}, 32'(chain_stb), 32'h0);
        checkOutput({tag, "_chain_mode"}, 32'(chain_mode), 32'h3);
        checkOutput({tag, "_inflight"}, 32'(inflight), 32'h0);
        checkOutput({tag, "_err_underflow"}, 32'(err_underflow), 32'h0);
    endtask

    task automatic doReset(input string tag);
        rst = 1'b0;
        #2;
        checkReset(tag);
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // One-cycle chain result, then the routed response is checked one cycle later.
    task automatic resultPulse(input logic [31:0] res, input logic [3:0] exp_rsp, input string tag);
        chain_res     = res;
        chain_res_stb = 1'b1;
        tick();
        chain_res_stb = 1'b0;
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp != 4'b0000) begin
            checkOutput({tag, "_rsp_data"}, rsp_data, res);
        end
    endtask

    initial begin
        rst           = 1'b0;
        req_valid     = '0;
        req_mode      = 8'hFF;
        req_data      = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'h3F804000};
        chain_res     = '0;
        chain_res_stb = 1'b0;
        $display("[TB] start");
        tick();
        tick();
        checkReset("por");
        rst = 1'b1;
        tick();

        // Single operation through a 6-cycle chain
        applyStimulus(4'b0001, 8'hFF);
        #1;
        checkOutput("t1_ready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(4'b0000, 8'hFF);
        checkOutput("t1_stb", 32'(chain_stb), 32'h1);
        checkOutput("t1_ins", chain_ins, 32'h3F804000);
        checkOutput("t1_inflight", 32'(inflight), 32'h1);
        tick();
        checkOutput("t1_stb_low", 32'(chain_stb), 32'h0);
        repeat (4) tick();
        resultPulse(32'h3F804000, 4'b0001, "t1");
        checkOutput("t1_inflight_end", 32'(inflight), 32'h0);
        tick();
        checkOutput("t1_rsp_low", 32'(rsp_valid), 32'h0);

        // Round-robin with all requesters valid until the FIFO fills
        doReset("rr");
        req_data[31:0] = 32'hC0DE0000;
        applyStimulus(4'b1111, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            checkOutput("rr_ins", chain_ins, 32'hC0DE0000 | 32'(k % 4));
        end
        #1;
        checkOutput("full_ready", 32'(req_ready), 32'h0);
        checkOutput("full_inflight", 32'(inflight), 32'h8);
        tick();
        checkOutput("full_stb_low", 32'(chain_stb), 32'h0);
        checkOutput("full_ready2", 32'(req_ready), 32'h0);
        chain_res     = 32'hBEEF0000;
        chain_res_stb = 1'b1;
        #1;
        checkOutput("full_pop_ready", 32'(req_ready), 32'h0);
        tick();
        chain_res_stb = 1'b0;
        checkOutput("full_pop_rsp", 32'(rsp_valid), 32'h1);
        checkOutput("full_pop_data", rsp_data, 32'hBEEF0000);
        checkOutput("full_pop_inflight", 32'(inflight), 32'h7);
        #1;
        checkOutput("refill_ready", 32'(req_ready), 32'h1);
        tick();
        checkOutput("refill_inflight", 32'(inflight), 32'h8);
        checkOutput("refill_ins", chain_ins, 32'hC0DE0000);
        checkOutput("refill_full", 32'(req_ready), 32'h0);
        applyStimulus(4'b0000, 8'hFF);

        // Tags now queued: 1,2,3,0,1,2,3,0
        resultPulse(32'h50000001, 4'b0010, "drain_a");
        resultPulse(32'h50000002, 4'b0100, "drain_b");
        resultPulse(32'h50000003, 4'b1000, "drain_c");
        checkOutput("pre_sim_inflight", 32'(inflight), 32'h5);

        // Accept and result in the same cycle
        applyStimulus(4'b0001, 8'hFF);
        chain_res     = 32'h50000004;
        chain_res_stb = 1'b1;
        #1;
        checkOutput("sim_ready", 32'(req_ready), 32'h1);
        tick();
        chain_res_stb = 1'b0;
        applyStimulus(4'b0000, 8'hFF);
        checkOutput("sim_inflight", 32'(inflight), 32'h5);
        checkOutput("sim_rsp", 32'(rsp_valid), 32'h1);
        checkOutput("sim_stb", 32'(chain_stb), 32'h1);
        resultPulse(32'h60000001, 4'b0010, "tail_a");
        resultPulse(32'h60000002, 4'b0100, "tail_b");
        resultPulse(32'h60000003, 4'b1000, "tail_c");
        resultPulse(32'h60000004, 4'b0001, "tail_d");
        resultPulse(32'h60000005, 4'b0001, "tail_e");
        checkOutput("tail_inflight", 32'(inflight), 32'h0);
        checkOutput("tail_no_err", 32'(err_underflow), 32'h0);

        // Spurious result on an empty FIFO
        resultPulse(32'h00000BAD, 4'b0000, "spur");
        checkOutput("spur_err", 32'(err_underflow), 32'h1);
        checkOutput("spur_inflight", 32'(inflight), 32'h0);
        repeat (3) tick();
        checkOutput("spur_sticky", 32'(err_underflow), 32'h1);

        // Mode switch: three mode-11 ops in flight, then req1 asks for mode 01
        doReset("sw");
        req_data[31:0] = 32'h3F804000;
        applyStimulus(4'b0001, 8'hFF);
        repeat (3) tick();
        checkOutput("sw_inflight", 32'(inflight), 32'h3);
        applyStimulus(4'b0010, 8'hF7);
        #1;
        checkOutput("sw_lock_ready", 32'(req_ready), 32'h0);
        tick();
        checkOutput("sw_drain_ready", 32'(req_ready), 32'h0);
        resultPulse(32'h70000001, 4'b0001, "sw_r0");
        checkOutput("sw_drain_ready0", 32'(req_ready), 32'h0);
        resultPulse(32'h70000002, 4'b0001, "sw_r1");
        checkOutput("sw_drain_ready1", 32'(req_ready), 32'h0);
        resultPulse(32'h70000003, 4'b0001, "sw_r2");
        checkOutput("sw_drain_ready2", 32'(req_ready), 32'h0);
        checkOutput("sw_empty", 32'(inflight), 32'h0);
        tick();
        checkOutput("sw_switch_ready", 32'(req_ready), 32'h0);
        checkOutput("sw_switch_mode", 32'(chain_mode), 32'h3);
        tick();
        checkOutput("sw_new_mode", 32'(chain_mode), 32'h1);
        checkOutput("sw_grant", 32'(req_ready), 32'h2);
        tick();
        checkOutput("sw_stb", 32'(chain_stb), 32'h1);
        checkOutput("sw_ins", chain_ins, 32'hC0DE0001);
        checkOutput("sw_inflight1", 32'(inflight), 32'h1);

        // Reset with four ops in flight
        repeat (3) tick();
        checkOutput("mid_inflight", 32'(inflight), 32'h4);
        rst = 1'b0;
        #1;
        checkReset("mid");
        applyStimulus(4'b0000, 8'hFF);
        tick();
        rst = 1'b1;
        tick();
        resultPulse(32'h80000001, 4'b0000, "post_a");
        resultPulse(32'h80000002, 4'b0000, "post_b");
        checkOutput("post_inflight", 32'(inflight), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
